// File: rtl/pri_enc_pkg.sv
// -----------------------------------------------------------------------------
// pri_enc_pkg
// Shared constants for the 8-to-3 priority encoder.
//   IN_W  : width of the request vector (fixed at 8 for this block)
//   OUT_W : width of the encoded index, clog2(IN_W), covering indices 0..7
// -----------------------------------------------------------------------------
package pri_enc_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = $clog2(IN_W);

endpackage : pri_enc_pkg

// File: rtl/pri_enc_core.sv
// -----------------------------------------------------------------------------
// pri_enc_core
// Purely combinational priority scan: finds the most significant set bit of d.
// Ports:
//   d      in  [IN_W-1:0]   request vector, bit i = request at index i
//   a_next out [OUT_W-1:0]  index of the highest set bit (0 when d is zero)
//   v_next out              1 when any bit of d is set
// -----------------------------------------------------------------------------
module pri_enc_core #(
    parameter int IN_W  = pri_enc_pkg::IN_W,
    parameter int OUT_W = pri_enc_pkg::OUT_W
) (
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] a_next,
    output logic             v_next
);

    import pri_enc_pkg::*;

    always_comb begin
        // Defaults first so an all-zero request yields a defined index of 0.
        a_next = '0;
        v_next = |d;
        // Ascending scan: a later (higher) set bit overwrites any lower one,
        // so the final value is the most significant request.
        for (int i = 0; i < IN_W; i++) begin
            if (d[i]) begin
                a_next = OUT_W'(i);
            end
        end
    end

endmodule : pri_enc_core

// File: rtl/pri_enc_8_to_3.sv
// -----------------------------------------------------------------------------
// pri_enc_8_to_3
// Registered 8-to-3 priority encoder. D[7] has the highest priority.
// One cycle of latency from D to A/V; no combinational path from D to outputs.
// Ports:
//   clk  in       rising-edge clock
//   rst  in       asynchronous, active-high reset; clears A and V at once
//   D    in  [7:0] request vector
//   A    out [2:0] registered index of the highest set request bit
//   V    out       registered valid, 1 when D was non-zero at the sampling edge
// -----------------------------------------------------------------------------
module pri_enc_8_to_3 #(
    parameter int IN_W  = pri_enc_pkg::IN_W,
    parameter int OUT_W = pri_enc_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  D,
    output logic [OUT_W-1:0] A,
    output logic             V
);

    import pri_enc_pkg::*;

    logic [OUT_W-1:0] a_next;
    logic             v_next;
    logic [OUT_W-1:0] a_reg;
    logic             v_reg;

    pri_enc_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .d      (D),
        .a_next (a_next),
        .v_next (v_next)
    );

    // Output register stage; reset takes effect without waiting for clk and
    // drops whatever sample would have been captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            v_reg <= 1'b0;
        end else begin
            a_reg <= a_next;
            v_reg <= v_next;
        end
    end

    assign A = a_reg;
    assign V = v_reg;

endmodule : pri_enc_8_to_3

// File: tb/tb_pri_enc_8_to_3.sv
module tb_pri_enc_8_to_3;

    logic       clk;
    logic       rst;
    logic [7:0] D;
    logic [2:0] A;
    logic       V;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [3:0] exp_q[$];   // {V, A} expected, pushed at drive time
    logic [3:0] last_exp;   // result currently expected on the outputs

    pri_enc_8_to_3 dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .A   (A),
        .V   (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search downward from bit 7 for the first set bit.
    function automatic logic [3:0] ref_enc(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            if (d[i] == 1'b1) return {1'b1, 3'(i)};
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got V=%b A=%0d exp V=%b A=%0d", tag, got[3], got[2:0], exp[3], exp[2:0]);
        end
    endtask

    // Drive one request vector, confirm the outputs do not react before the
    // clock edge, then pop the expected result and compare after the edge.
    task automatic apply(input logic [7:0] d, input string tag);
        logic [3:0] exp;
        @(negedge clk);
        D = d;
        exp_q.push_back(ref_enc(d));
        #1;
        chk({tag, "_hold"}, {V, A}, last_exp);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk(tag, {V, A}, exp);
        last_exp = exp;
        $display("txn %s D=%h A=%0d V=%b", tag, d, A, V);
    endtask

    initial begin
        rst      = 1'b1;
        D        = 8'h00;
        last_exp = 4'b0000;

        // Reset state, including across a clock edge while held.
        #1;
        chk("rst_state", {V, A}, 4'b0000);
        @(posedge clk);
        #1;
        chk("rst_edge", {V, A}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Zero input after reset.
        apply(8'h00, "zero");

        // One-hot walk including a zero step.
        apply(8'h80, "walk80");
        apply(8'h40, "walk40");
        apply(8'h20, "walk20");
        apply(8'h10, "walk10");
        apply(8'h08, "walk08");
        apply(8'h00, "walk00");
        apply(8'h04, "walk04");
        apply(8'h02, "walk02");
        apply(8'h01, "walk01");

        // Multi-bit requests.
        apply(8'hFF, "multiFF");
        apply(8'h0A, "multi0A");
        apply(8'h81, "multi81");
        apply(8'h03, "multi03");

        // Asynchronous reset between edges while A=5, V=1.
        apply(8'h20, "pre_rst");
        @(negedge clk);
        D = 8'h10;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {V, A}, 4'b0000);
        $display("txn rst_async A=%0d V=%b", A, V);
        @(posedge clk);
        #1;
        chk("rst_held", {V, A}, 4'b0000);

        // Deassert with D=8'h10 held: nothing until the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_before", {V, A}, 4'b0000);
        @(posedge clk);
        #1;
        chk("rel_first", {V, A}, ref_enc(8'h10));
        chk("rel_expect", {V, A}, 4'b1100);
        $display("txn rel_first D=%h A=%0d V=%b", D, A, V);
        last_exp = 4'b1100;

        // Random traffic against the reference model.
        for (int n = 0; n < 1000; n++) begin
            apply(8'($urandom_range(0, 255)), "rand");
        end

        if (exp_q.size() != 0) begin
            bad_cnt++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_pri_enc_8_to_3

// File: doc/pri_enc_8_to_3.md
PRI_ENC_8_TO_3 -- requirements
Module: pri_enc_8_to_3

Interface
REQ-001 Parameter IN_W, default 8: input vector width; SHALL be 8 in this block, and other values are unsupported.
REQ-002 Parameter OUT_W, default 3: encoded index width, equal to clog2(IN_W).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 D  input  8  request vector; bit i set means request at index i.
REQ-006 A  output  3  registered binary index of the highest-priority active request.
REQ-007 V  output  1  registered valid; 1 when at least one bit of D was set at the sampling edge.

Function
REQ-008 Priority SHALL be by bit index: D[7] highest, D[0] lowest.
REQ-009 On each rising clk edge with rst low, the block SHALL sample D and, from that edge onward, drive A = index of the most significant set bit of D.
REQ-010 On that same edge, V SHALL be driven to 1 if D is non-zero.
REQ-011 When D == 8'h00 at the edge, the block SHALL drive V = 0 and A = 3'd0; A is defined, never X.
REQ-012 Latency SHALL be exactly 1 cycle from D sampled to A/V valid, with no combinational path from D to A or V.
REQ-013 Any number of simultaneously set bits SHALL resolve to the highest set index only (e.g. D = 8'hFF gives A = 7).
REQ-014 The block SHALL have no handshake and no back-pressure; a new result is produced every cycle and outputs hold between edges.
REQ-015 The block SHALL contain no state machine beyond the output registers.
REQ-016 The encoder SHALL be width-safe: no truncation warnings, and OUT_W bits exactly cover indices 0..7.

Reset
REQ-017 While rst is high, A SHALL be 3'd0 and V SHALL be 0, immediately and independently of clk.
REQ-018 Assertion of rst mid-operation SHALL clear A and V asynchronously and discard the in-flight sample.
REQ-019 After rst deasserts, the first valid result SHALL appear at the first rising clk edge following deassertion, using D sampled at that edge.

Structure
REQ-020 Constants IN_W = 8 and OUT_W = 3 SHALL live in a shared package pri_enc_pkg, and the top SHALL import it.
REQ-021 One combinational sub-module, pri_enc_core, SHALL compute the next A and V from D.
REQ-022 The top SHALL contain only the asynchronous-reset output register stage around pri_enc_core.
REQ-023 pri_enc_core SHALL have a fully specified output for every input combination: a default assignment precedes the priority scan, and no latches are inferred.

Verification
REQ-024 Reset then D = 8'h00 -> after one edge, V = 0 and A = 0.
REQ-025 Walk one-hot D = 8'h80, 40, 20, 10, 08, then 00, then 04, 02, 01 (one per cycle) -> A = 7, 6, 5, 4, 3, then (V = 0, A = 0), then 2, 1, 0; V = 1 on every non-zero step; each result appears one cycle after its D.
REQ-026 Multi-bit D = 8'hFF -> A = 7; D = 8'h0A -> A = 3; D = 8'h81 -> A = 7; D = 8'h03 -> A = 1; V = 1 in all four cases.
REQ-027 Assert rst between edges while V = 1, A = 5 -> A = 0 and V = 0 immediately, not waiting for clk.
REQ-028 Deassert rst with D = 8'h10 held -> A = 4, V = 1 at the first rising edge after deassertion, and not before.
REQ-029 Random D for 1000 cycles -> A and V match a reference model (highest set bit, V = |D) delayed by one cycle.
